// File: rtl/dcache_dm_wt_if.sv
// dcache_dm_wt_if: MEM-stage d_* request port plus the word-at-a-time memory port of dcache_dm_wt.
// slave is the cache's view; master is the CPU/memory environment's view.
interface dcache_dm_wt_if;
  logic [1:0]  d_en;
  logic [31:0] d_addr;
  logic [2:0]  d_size;
  logic [3:0]  w_byte_select;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [2:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  modport slave (
    input  d_en, d_addr, d_size, w_byte_select, d_wdata, mem_rdata, mem_ack,
    output d_rdata, d_stall, mem_req, mem_we, mem_addr, mem_size, mem_wstrb, mem_wdata
  );
  modport master (
    output d_en, d_addr, d_size, w_byte_select, d_wdata, mem_rdata, mem_ack,
    input  d_rdata, d_stall, mem_req, mem_we, mem_addr, mem_size, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/dcache_dm_wt.sv
// dcache_dm_wt: direct-mapped, write-through, no-write-allocate data cache with word-beat refill.
// Defining DCACHE_UNCACHED_EN makes kseg1 (d_addr[31:29]==3'b101) bypass the line array.
module dcache_dm_wt #(
  parameter int INDEX_W    = 6,
  parameter int WORD_OFF_W = 2
) (
  input logic           clk,
  input logic           resetn,
  dcache_dm_wt_if.slave bus
);
  localparam int LINES = 2 ** INDEX_W;
  localparam int LW    = 2 ** WORD_OFF_W;
  localparam int TAG_W = 30 - INDEX_W - WORD_OFF_W;
  localparam int TLO   = 2 + WORD_OFF_W + INDEX_W;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE, UNC_RD} state_t;
  state_t                state;
  logic [LINES-1:0]      valid;
  logic [TAG_W-1:0]      tag_ram [LINES];
  logic [31:0]           data [LINES*LW];
  logic [WORD_OFF_W-1:0] beat, off;
  logic [INDEX_W-1:0]    idx, fill_idx;
  logic [TAG_W-1:0]      tag;
  logic                  acc, load, hit, unc, ready;
  logic                  unused;
  assign tag      = bus.d_addr[31:TLO];
  assign idx      = bus.d_addr[TLO-1:2+WORD_OFF_W];
  assign off      = bus.d_addr[2+WORD_OFF_W-1:2];
  assign fill_idx = bus.mem_addr[TLO-1:2+WORD_OFF_W];
  assign acc      = bus.d_en == 2'b01;
  assign load     = bus.w_byte_select == 4'b0;
  assign hit      = valid[idx] && tag_ram[idx] == tag;
  assign unused   = ^bus.d_addr[1:0];
`ifdef DCACHE_UNCACHED_EN
  logic        ur_done;
  logic [31:0] ur_data;
  assign unc         = bus.d_addr[31:29] == 3'b101;
  assign ready       = unc ? ur_done : hit;
  assign bus.d_rdata = unc ? ur_data : data[{idx, off}];
  // the bypassed word is offered for exactly the one cycle after its ack
  always_ff @(posedge clk) begin
    ur_done <= resetn && state == UNC_RD && bus.mem_ack;
    if (state == UNC_RD && bus.mem_ack) ur_data <= bus.mem_rdata;
  end
`else
  assign unc         = 1'b0;
  assign ready       = hit;
  assign bus.d_rdata = data[{idx, off}];
`endif
  // a store completes in the cycle its ack arrives; everything else waits for IDLE
  assign bus.d_stall = state == WRITE ? !bus.mem_ack : (state != IDLE) || (acc && !(load && ready));
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      valid         <= '0;
      beat          <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_size  <= '0;
      bus.mem_wstrb <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc && !load) begin
            state         <= WRITE;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= {bus.d_addr[31:2], 2'b00};
            bus.mem_size  <= bus.d_size;
            bus.mem_wstrb <= bus.w_byte_select;
            bus.mem_wdata <= bus.d_wdata;
          end else if (acc && !ready) begin
            state         <= unc ? UNC_RD : REFILL;
            beat          <= '0;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_wstrb <= '0;
            bus.mem_size  <= unc ? bus.d_size : 3'd2;
            bus.mem_addr  <= unc ? {bus.d_addr[31:2], 2'b00}
                                 : {bus.d_addr[31:2+WORD_OFF_W], {(WORD_OFF_W+2){1'b0}}};
          end
        end
        REFILL: begin
          if (bus.mem_ack) begin
            beat         <= beat + 1'b1;
            bus.mem_addr <= bus.mem_addr + 32'd4;
            if (&beat) begin
              valid[fill_idx] <= 1'b1;
              bus.mem_req     <= 1'b0;
              state           <= IDLE;
            end
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            bus.mem_req   <= 1'b0;
            bus.mem_wstrb <= '0;
            state         <= IDLE;
          end
        end
        default: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            state       <= IDLE;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (resetn && state == REFILL && bus.mem_ack) begin
      data[{fill_idx, beat}] <= bus.mem_rdata;
      if (&beat) tag_ram[fill_idx] <= bus.mem_addr[31:TLO];
    end
    if (resetn && state == IDLE && acc && !load && hit && !unc)
      for (int b = 0; b < 4; b++)
        if (bus.w_byte_select[b]) data[{idx, off}][8*b +: 8] <= bus.d_wdata[8*b +: 8];
  end
endmodule
